sqdiff_sched: RTL and testbench

SQDIFF_SCHED -- requirements
Module: sqdiff_sched

---
 rtl/sqdiff_pkg.sv | 19 +
 rtl/sqdiff_sched_if.sv | 30 +++
 rtl/sqdiff_pipe.sv | 52 +++++
 rtl/sqdiff_sched.sv | 132 +++++++++++++
 tb/tb_sqdiff_sched.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sqdiff_pkg.sv
// Shared widths and types for the square-difference scheduler.
//   OP_W    : operand width
//   T_W     : width of the sum/difference terms T1 and T2
//   RES_W   : result width (C = T1*T2 mod 1024)
//   LATENCY : cycles from the accept edge to the FIFO write edge
package sqdiff_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned T_W     = 5;
  localparam int unsigned RES_W   = 10;
  localparam int unsigned LATENCY = 3;

  // Operand pair carried from the arbiter into the datapath
  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } operand_t;

endpackage

// File: rtl/sqdiff_sched_if.sv
// Request/response bundle of the scheduler.
//   req_valid/req_ready : per-requester handshake, one-hot grant
//   req_a/req_b         : packed operands, requester i at [4i+3:4i]
//   rsp_valid/rsp_ready : result FIFO head handshake
//   rsp_id/rsp_c        : requester index and result of the head entry
// master = requesters + consumer side, slave = scheduler side.
interface sqdiff_sched_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]                   req_valid;
  logic [sqdiff_pkg::OP_W*N_REQ-1:0]  req_a;
  logic [sqdiff_pkg::OP_W*N_REQ-1:0]  req_b;
  logic [N_REQ-1:0]                   req_ready;
  logic                               rsp_valid;
  logic                               rsp_ready;
  logic [ID_W-1:0]                    rsp_id;
  logic [sqdiff_pkg::RES_W-1:0]       rsp_c;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_c
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_c
  );
endinterface

// File: rtl/sqdiff_pipe.sv
// Three-stage datapath: stage1 T1=(A+B) mod 32 and T2=(A-B) mod 32,
// stage2 product T1*T2 mod 1024, stage3 output register feeding the FIFO.
// Ports: clk, rst_n (sync, active-low), in_valid/in_id/in_op in,
// out_valid/out_id/out_c out. No stall input; the caller guarantees room.
module sqdiff_pipe
  import sqdiff_pkg::*;
#(
  parameter int unsigned ID_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [ID_W-1:0]  in_id,
  input  operand_t         in_op,
  output logic             out_valid,
  output logic [ID_W-1:0]  out_id,
  output logic [RES_W-1:0] out_c
);

  logic             s1_valid;
  logic             s2_valid;
  logic [ID_W-1:0]  s1_id;
  logic [ID_W-1:0]  s2_id;
  logic [T_W-1:0]   s1_t1;
  logic [T_W-1:0]   s1_t2;
  logic [RES_W-1:0] s2_p;

  // Valid chain; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
    end
  end

  // Data and id travel with the valids; 5-bit arithmetic wraps mod 32
  always_ff @(posedge clk) begin
    s1_id  <= in_id;
    s1_t1  <= T_W'(in_op.a) + T_W'(in_op.b);
    s1_t2  <= T_W'(in_op.a) - T_W'(in_op.b);
    s2_id  <= s1_id;
    s2_p   <= RES_W'(s1_t1) * RES_W'(s1_t2);
    out_id <= s2_id;
    out_c  <= s2_p;
  end

endmodule

// File: rtl/sqdiff_sched.sv
// Round-robin scheduler in front of the square-difference pipeline with a
// credit-protected result FIFO.
// Ports: clk, rst_n (sync, active-low), bus (sqdiff_sched_if.slave).
// Optional: SQDIFF_SCHED_STATS_EN adds output stall_cnt[15:0], the count of
// cycles with any request valid but no transfer (saturating).
module sqdiff_sched
  import sqdiff_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  sqdiff_sched_if.slave   bus
`ifdef SQDIFF_SCHED_STATS_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  cand;
  logic [N_REQ-1:0] grant;
  logic             found;
  logic [CNT_W-1:0] used;       // entries in flight plus entries queued
  logic             has_credit;
  logic             xfer;
  logic             pop;
  operand_t         op_sel;

  logic             p_valid;
  logic [ID_W-1:0]  p_id;
  logic [RES_W-1:0] p_c;

  logic [ID_W-1:0]  mem_id [FIFO_DEPTH];
  logic [RES_W-1:0] mem_c  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  assign has_credit = (used < CNT_W'(FIFO_DEPTH));

  // Round-robin search starting just after the last granted requester
  always_comb begin
    grant    = '0;
    grant_id = '0;
    cand     = '0;
    found    = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((32'(last_grant) + k) % N_REQ);
      if (!found && bus.req_valid[cand]) begin
        found       = 1'b1;
        grant_id    = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  // Grant is suppressed under reset and when no credit is left
  assign bus.req_ready = (rst_n && has_credit) ? grant : '0;
  assign xfer          = |bus.req_ready;

  // Operand mux for the granted requester
  always_comb begin
    op_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        op_sel.a = bus.req_a[i*OP_W +: OP_W];
        op_sel.b = bus.req_b[i*OP_W +: OP_W];
      end
    end
  end

  sqdiff_pipe #(.ID_W(ID_W)) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (xfer),
    .in_id     (grant_id),
    .in_op     (op_sel),
    .out_valid (p_valid),
    .out_id    (p_id),
    .out_c     (p_c)
  );

  assign bus.rsp_valid = (count != '0);
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  // Head is masked to zero when empty so idle/reset outputs read as 0
  assign bus.rsp_id    = bus.rsp_valid ? mem_id[rd_ptr] : '0;
  assign bus.rsp_c     = bus.rsp_valid ? mem_c[rd_ptr]  : '0;

  // Arbiter pointer, credit and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= ID_W'(N_REQ - 1);
      used       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (xfer) last_grant <= grant_id;
      if (p_valid) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      used  <= used + CNT_W'(xfer) - CNT_W'(pop);
      count <= count + CNT_W'(p_valid) - CNT_W'(pop);
    end
  end

  // FIFO storage; credit guarantees the written slot is free
  always_ff @(posedge clk) begin
    if (rst_n && p_valid) begin
      mem_id[wr_ptr] <= p_id;
      mem_c[wr_ptr]  <= p_c;
    end
  end

`ifdef SQDIFF_SCHED_STATS_EN
  // Stall counter, saturating
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((|bus.req_valid) && !xfer && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sqdiff_sched.sv
// Self-checking bench for sqdiff_sched with a queue-based reference model.
module tb_sqdiff_sched;
  import sqdiff_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned FD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sqdiff_sched_if #(.N_REQ(NR)) bus ();
`ifdef SQDIFF_SCHED_STATS_EN
  logic [15:0] stall_cnt;
`endif

  sqdiff_sched #(.N_REQ(NR), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SQDIFF_SCHED_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct { int id; int c; int vis; } exp_t;
  exp_t q[$];
  int   m_last;
  int   cyc;
  int   m_stall;
  int   checks = 0;
  int   failures = 0;

  logic [NR-1:0] e_ready;
  logic          e_rv;
  logic [1:0]    e_id;
  logic [9:0]    e_c;

  function automatic int ref_c(int a, int b);
    int t1;
    int t2;
    t1 = (a + b) % 32;
    t2 = (a - b + 32) % 32;
    return (t1 * t2) % 1024;
  endfunction

  task automatic model_reset();
    q.delete();
    m_last  = NR - 1;
    cyc     = 0;
    m_stall = 0;
  endtask

  // Expected outputs for the current cycle from the model state
  task automatic model_eval();
    e_ready = '0;
    if (rst_n && q.size() < FD) begin
      for (int k = 1; k <= NR; k++) begin
        int i;
        i = (m_last + k) % NR;
        if (bus.req_valid[i] === 1'b1) begin
          e_ready[i] = 1'b1;
          break;
        end
      end
    end
    e_rv = 1'b0; e_id = '0; e_c = '0;
    if (q.size() > 0) begin
      if (q[0].vis <= cyc) begin
        e_rv = 1'b1;
        e_id = 2'(q[0].id);
        e_c  = 10'(q[0].c);
      end
    end
  endtask

  // Apply the upcoming clock edge to the model
  task automatic model_commit();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (e_rv && bus.rsp_ready === 1'b1) void'(q.pop_front());
    for (int i = 0; i < NR; i++) begin
      if (e_ready[i]) begin
        q.push_back('{i, ref_c(int'(bus.req_a[4*i +: 4]), int'(bus.req_b[4*i +: 4])),
                      cyc + 1 + int'(LATENCY)});
        m_last = i;
      end
    end
    if ((|bus.req_valid) && e_ready == '0 && m_stall < 65535) m_stall++;
    cyc++;
  endtask

  task automatic tick_pre();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick_post();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NR-1:0] v, input logic [4*NR-1:0] a,
                       input logic [4*NR-1:0] b, input logic rr);
    bus.req_valid = v; bus.req_a = a; bus.req_b = b; bus.rsp_ready = rr;
  endtask

  task automatic idle(input int n);
    drive('0, '0, '0, 1'b1);
    for (int i = 0; i < n; i++) begin
      tick_pre();
      tick_post();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive('1, 16'hFFFF, 16'h1234, 1'b1);
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    checks++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 || bus.rsp_id !== '0 || bus.rsp_c !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b rsp_valid=%b id=%0d c=%0d, want all zero",
               bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_c);
    end
`ifdef SQDIFF_SCHED_STATS_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive('0, '0, '0, 1'b1);
  endtask

  task automatic test_single();
    int acc_cyc; int first_cyc; logic [9:0] first_c; logic [1:0] first_id;
    acc_cyc = -1; first_cyc = -1; first_c = '0; first_id = '0;
    drive(4'b0001, 16'h0001, 16'h0002, 1'b1);
    for (int n = 0; n < 7; n++) begin
      tick_pre();
      checks++;
      if (bus.req_ready !== e_ready || bus.rsp_valid !== e_rv) begin
        failures++;
        $display("FAIL single_hs: ready=%b rsp_valid=%b, want ready=%b rsp_valid=%b",
                 bus.req_ready, bus.rsp_valid, e_ready, e_rv);
      end
      if (bus.req_ready[0] === 1'b1 && acc_cyc < 0) acc_cyc = cyc + 1;
      if (bus.rsp_valid === 1'b1 && first_cyc < 0) begin
        first_cyc = cyc; first_c = bus.rsp_c; first_id = bus.rsp_id;
      end
      tick_post();
      bus.req_valid = '0;
    end
    checks++;
    if (first_cyc - acc_cyc != 3 || first_c !== 10'd93 || first_id !== 2'd0) begin
      failures++;
      $display("FAIL single_result: latency=%0d c=%0d id=%0d, want latency=3 c=93 id=0",
               first_cyc - acc_cyc, first_c, first_id);
    end
  endtask

  task automatic test_back_to_back();
    int got_c[$]; int got_cyc[$]; int got_id[$];
    drive(4'b0010, 16'h0030, 16'h0050, 1'b1);
    for (int n = 0; n < 9; n++) begin
      tick_pre();
      checks++;
      if (bus.req_ready !== e_ready || bus.rsp_valid !== e_rv) begin
        failures++;
        $display("FAIL b2b_hs: ready=%b rsp_valid=%b, want ready=%b rsp_valid=%b",
                 bus.req_ready, bus.rsp_valid, e_ready, e_rv);
      end
      if (bus.rsp_valid === 1'b1) begin
        got_c.push_back(int'(bus.rsp_c)); got_cyc.push_back(cyc); got_id.push_back(int'(bus.rsp_id));
      end
      tick_post();
      if (n == 0) drive(4'b0010, 16'h0060, 16'h0020, 1'b1);
      else bus.req_valid = '0;
    end
    checks++;
    if (got_c.size() != 2) begin
      failures++;
      $display("FAIL b2b_count: got %0d results want 2", got_c.size());
    end else if (got_c[0] != 240 || got_c[1] != 32 || got_cyc[1] != got_cyc[0] + 1 ||
                 got_id[0] != 1 || got_id[1] != 1) begin
      failures++;
      $display("FAIL b2b_results: c=%0d,%0d ids=%0d,%0d gap=%0d, want 240,32 ids 1,1 gap 1",
               got_c[0], got_c[1], got_id[0], got_id[1], got_cyc[1] - got_cyc[0]);
    end
  endtask

  task automatic test_round_robin();
    int grants[$]; int start;
    start = (m_last + 1) % NR;
    for (int n = 0; n < 16; n++) begin
      drive('1, 16'($urandom), 16'($urandom), 1'b1);
      tick_pre();
      checks++;
      if (bus.req_ready !== e_ready || !$onehot0(bus.req_ready)) begin
        failures++;
        $display("FAIL rr_grant: ready=%b want %b", bus.req_ready, e_ready);
      end
      if (e_rv) begin
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== e_id || bus.rsp_c !== e_c) begin
          failures++;
          $display("FAIL rr_head: valid=%b id=%0d c=%0d want 1 id=%0d c=%0d",
                   bus.rsp_valid, bus.rsp_id, bus.rsp_c, e_id, e_c);
        end
      end
      for (int i = 0; i < NR; i++) if (bus.req_ready[i] === 1'b1) grants.push_back(i);
      tick_post();
    end
    checks++;
    begin
      bit ok;
      ok = (grants.size() >= 8);
      for (int k = 0; k < grants.size(); k++) if (grants[k] != (start + k) % NR) ok = 1'b0;
      if (!ok) begin
        failures++;
        $display("FAIL rr_order: %0d grants, first=%0d, want rotating order from %0d",
                 grants.size(), grants.size() > 0 ? grants[0] : -1, start);
      end
    end
    idle(6);
  endtask

  task automatic test_backpressure();
    int acc; int acc2;
    acc = 0; acc2 = 0;
    for (int n = 0; n < 8; n++) begin
      drive(4'b0001, 16'($urandom), 16'($urandom), 1'b0);
      tick_pre();
      if (bus.req_ready[0] === 1'b1) acc++;
      if (n == 7) begin
        checks++;
        if (bus.req_ready !== '0) begin
          failures++;
          $display("FAIL bp_full_ready: ready=%b want 0000", bus.req_ready);
        end
      end
      tick_post();
    end
    checks++;
    if (acc != 4) begin
      failures++;
      $display("FAIL bp_accepts: got %0d want 4", acc);
    end
    for (int n = 0; n < 12; n++) begin
      drive(4'b0001, 16'($urandom), 16'($urandom), 1'b1);
      tick_pre();
      checks++;
      if (bus.req_ready !== e_ready || bus.rsp_valid !== e_rv) begin
        failures++;
        $display("FAIL bp_drain_hs: ready=%b rsp_valid=%b, want ready=%b rsp_valid=%b",
                 bus.req_ready, bus.rsp_valid, e_ready, e_rv);
      end
      if (e_rv) begin
        checks++;
        if (bus.rsp_id !== e_id || bus.rsp_c !== e_c) begin
          failures++;
          $display("FAIL bp_drain_head: id=%0d c=%0d want id=%0d c=%0d",
                   bus.rsp_id, bus.rsp_c, e_id, e_c);
        end
      end
      if (bus.req_ready[0] === 1'b1) acc2++;
      tick_post();
    end
    checks++;
    if (acc2 == 0) begin
      failures++;
      $display("FAIL bp_resume: got %0d accepts after release want >0", acc2);
    end
    idle(6);
  endtask

  task automatic test_edges();
    int got_c[$]; int got_id[$];
    logic [15:0] ea [3]; logic [15:0] eb [3];
    ea = '{16'h0F00, 16'h0F00, 16'h0000};
    eb = '{16'h0F00, 16'h0000, 16'h0F00};
    for (int n = 0; n < 10; n++) begin
      if (n < 3) drive(4'b0100, ea[n], eb[n], 1'b1);
      else bus.req_valid = '0;
      tick_pre();
      checks++;
      if (bus.req_ready !== e_ready || bus.rsp_valid !== e_rv) begin
        failures++;
        $display("FAIL edge_hs: ready=%b rsp_valid=%b, want ready=%b rsp_valid=%b",
                 bus.req_ready, bus.rsp_valid, e_ready, e_rv);
      end
      if (bus.rsp_valid === 1'b1) begin
        got_c.push_back(int'(bus.rsp_c)); got_id.push_back(int'(bus.rsp_id));
      end
      tick_post();
    end
    checks++;
    if (got_c.size() != 3) begin
      failures++;
      $display("FAIL edge_count: got %0d results want 3", got_c.size());
    end else if (got_c[0] != 0 || got_c[1] != 225 || got_c[2] != 255 ||
                 got_id[0] != 2 || got_id[2] != 2) begin
      failures++;
      $display("FAIL edge_results: c=%0d,%0d,%0d id=%0d want 0,225,255 id=2",
               got_c[0], got_c[1], got_c[2], got_id[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive(4'($urandom), 16'($urandom), 16'($urandom), ($urandom_range(0, 9) < 7));
      tick_pre();
      checks++;
      if (bus.req_ready !== e_ready || bus.rsp_valid !== e_rv) begin
        failures++;
        $display("FAIL rand_hs[%0d]: ready=%b rsp_valid=%b, want ready=%b rsp_valid=%b",
                 n, bus.req_ready, bus.rsp_valid, e_ready, e_rv);
      end
      if (e_rv) begin
        checks++;
        if (bus.rsp_id !== e_id || bus.rsp_c !== e_c) begin
          failures++;
          $display("FAIL rand_head[%0d]: id=%0d c=%0d want id=%0d c=%0d",
                   n, bus.rsp_id, bus.rsp_c, e_id, e_c);
        end
      end
      tick_post();
    end
`ifdef SQDIFF_SCHED_STATS_EN
    checks++;
    if (stall_cnt !== 16'(m_stall)) begin
      failures++;
      $display("FAIL rand_stall_cnt: got %0d want %0d", stall_cnt, m_stall);
    end
`endif
    idle(6);
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 5; n++) begin
      drive(4'b0001, 16'($urandom), 16'($urandom), 1'b0);
      tick_pre();
      tick_post();
    end
    checks++;
    if (q.size() != 4 || bus.rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL rmid_setup: model entries=%0d rsp_valid=%b want 4 and 1", q.size(), bus.rsp_valid);
    end
    rst_n = 1'b0;
    drive('0, '0, '0, 1'b0);
    tick_pre();
    tick_post();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick_pre();
      checks++;
      if (bus.rsp_valid !== 1'b0 || e_rv !== 1'b0) begin
        failures++;
        $display("FAIL rmid_stale[%0d]: rsp_valid=%b c=%0d want 0", n, bus.rsp_valid, bus.rsp_c);
      end
`ifdef SQDIFF_SCHED_STATS_EN
      if (n == 0) begin
        checks++;
        if (stall_cnt !== 16'd0) begin
          failures++;
          $display("FAIL rmid_stall_cnt: got %0d want 0", stall_cnt);
        end
      end
`endif
      tick_post();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive('0, '0, '0, 1'b0);
    test_reset();
    test_single();
    test_back_to_back();
    test_round_robin();
    test_backpressure();
    test_edges();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
